uart_word_arbiter: RTL and testbench

//  Shares one UART byte transmitter between NUM_REQ 32-bit word requesters.
//  - Round-robin arbitration.
//  - Latches the granted word and sends it LSB byte first, 4 bytes per word.
//  - Paces bytes on the transmitter's byte_sent pulse.
//  - Acknowledges the requester once the last byte has gone out.

---
 rtl/io_pkg.sv | 10 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/uart_word_arbiter.sv | 108 ++++++++++
 tb/tb_uart_word_arbiter.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// Shared I/O subsystem types and constants for the word-to-UART transmit path.
package io_pkg;

    typedef enum logic [1:0] {IDLE, SEND, WAIT, ACK} wtx_state_t;

    localparam int WORD_BYTES = 4;
    localparam int BYTE_W     = 8;
    localparam int WORD_W     = 32;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted req at ptr, ptr+1, ... modulo N.
module rr_arbiter #(
    parameter int N = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] grant_idx,
    output logic          grant_valid
);

    // One extra bit so ptr+k never overflows before the modulo fold.
    logic [IW:0] cand;

    always_comb begin
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand        = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = {1'b0, ptr} + (IW+1)'(k);
            if (cand >= (IW+1)'(N)) begin
                cand = cand - (IW+1)'(N);
            end
            if (!grant_valid && req[cand[IW-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = cand[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/uart_word_arbiter.sv
// Shares one UART byte transmitter among NUM_REQ 32-bit word requesters,
// round-robin, sending each granted word LSB byte first and acking when done.
module uart_word_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int WORD_BYTES = 4,
    localparam int IW = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*8*WORD_BYTES-1:0] word_in,
    output logic [NUM_REQ-1:0]            word_ack,
    input  logic                          byte_sent,
    output logic [7:0]                    byte_out,
    output logic                          uart_send,
    output logic                          busy,
    output logic [IW-1:0]                 grant_idx
);

    import io_pkg::*;

    localparam logic [1:0] LAST_BYTE = 2'(WORD_BYTES - 1);

    wtx_state_t state, state_next;

    logic [NUM_REQ-1:0][WORD_W-1:0]       words;
    logic [WORD_BYTES-1:0][BYTE_W-1:0]    word_q;
    logic [1:0]                           byte_cnt;
    logic [IW-1:0]                        ptr;
    logic [IW-1:0]                        grant_q;
    logic [IW-1:0]                        arb_idx;
    logic                                 arb_valid;

    always_comb words = word_in;

    rr_arbiter #(
        .N(NUM_REQ)
    ) u_arb (
        .req         (req),
        .ptr         (ptr),
        .grant_idx   (arb_idx),
        .grant_valid (arb_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (arb_valid) state_next = SEND;
            SEND: state_next = WAIT;
            WAIT: if (byte_sent) state_next = (byte_cnt == LAST_BYTE) ? ACK : SEND;
            ACK:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // grant_q is cleared on leaving ACK so grant_idx reads 0 while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_q   <= '0;
            byte_cnt <= '0;
            ptr      <= '0;
            grant_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_valid) begin
                        word_q   <= words[arb_idx];
                        grant_q  <= arb_idx;
                        byte_cnt <= '0;
                    end
                end
                WAIT: begin
                    if (byte_sent && byte_cnt != LAST_BYTE) begin
                        byte_cnt <= byte_cnt + 2'd1;
                    end
                end
                ACK: begin
                    ptr     <= (grant_q == IW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
                    grant_q <= '0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        uart_send = (state == SEND);
        busy      = (state != IDLE);
        grant_idx = grant_q;
        byte_out  = '0;
        word_ack  = '0;
        if (state == SEND || state == WAIT) begin
            byte_out = word_q[byte_cnt];
        end
        if (state == ACK) begin
            word_ack[grant_q] = 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_word_arbiter.sv
// Randomized bench for uart_word_arbiter against a transaction-level round-robin model.
module tb_uart_word_arbiter;

    localparam int N = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*32-1:0] word_in;
    logic [N-1:0]    word_ack;
    logic            byte_sent;
    logic [7:0]      byte_out;
    logic            uart_send;
    logic            busy;
    logic [1:0]      grant_idx;

    always #5 clk = ~clk;

    uart_word_arbiter #(
        .NUM_REQ    (N),
        .WORD_BYTES (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .word_in   (word_in),
        .word_ack  (word_ack),
        .byte_sent (byte_sent),
        .byte_out  (byte_out),
        .uart_send (uart_send),
        .busy      (busy),
        .grant_idx (grant_idx)
    );

    int checks = 0;
    int fails  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    // Model state: who owns the transmitter, which word, how many bytes seen.
    int          ptr_m     = 0;
    int          cur_owner = 0;
    int          nbytes    = 0;
    int          resp_cnt  = 0;
    int          words_done = 0;
    logic [31:0] cur_word  = '0;
    bit          in_word   = 1'b0;
    bit          exp_send  = 1'b0;
    bit          exp_ack   = 1'b0;
    bit          reset_seen = 1'b0;
    bit          ack_now;
    bit          rst_now;

    initial begin
        rst       = 1'b1;
        req       = '0;
        word_in   = '0;
        byte_sent = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);

        check("rst_busy",      busy,      1'b0);
        check("rst_uart_send", uart_send, 1'b0);
        check("rst_word_ack",  word_ack,  '0);
        check("rst_byte_out",  byte_out,  '0);
        check("rst_grant_idx", grant_idx, '0);

        // All requesters asserted at reset exit; requester 0 gets a recognisable word.
        rst = 1'b0;
        req = '1;
        word_in[31:0] = 32'hDDCC_BBAA;
        for (int i = 1; i < N; i++) word_in[i*32 +: 32] = $urandom;
        exp_send = 1'b1;

        for (int cyc = 0; cyc < 6000; cyc++) begin
            @(negedge clk);
            ack_now = 1'b0;
            rst_now = 1'b0;

            if (reset_seen) begin
                check("post_rst_byte_out", byte_out, '0);
                check("post_rst_word_ack", word_ack, '0);
                reset_seen = 1'b0;
            end

            check("uart_send_timing", uart_send, exp_send);
            check("word_ack_timing", |word_ack, exp_ack);

            if (uart_send) begin
                if (!in_word) begin
                    cur_owner = rr_pick(req, ptr_m);
                    check("grant_exists", cur_owner >= 0, 1'b1);
                    if (cur_owner < 0) cur_owner = 0;
                    cur_word = word_in[cur_owner*32 +: 32];
                    in_word  = 1'b1;
                    nbytes   = 0;
                end
                check("byte_out", byte_out, (nbytes < 4) ? 32'(cur_word[nbytes*8 +: 8]) : 32'hFFFF_FFFF);
                nbytes++;
                resp_cnt = $urandom_range(1, 4);
            end

            check("busy", busy, in_word);
            check("grant_idx", grant_idx, in_word ? cur_owner : 0);

            if (exp_ack) begin
                check("ack_onehot", word_ack, 32'(1 << cur_owner));
                check("ack_bytes", nbytes, 4);
                ptr_m   = (cur_owner + 1) % N;
                in_word = 1'b0;
                nbytes  = 0;
                ack_now = 1'b1;
                words_done++;
                // Usually drop the request; sometimes hold it as a fresh word.
                if ($urandom_range(0, 3) == 0) word_in[cur_owner*32 +: 32] = $urandom;
                else req[cur_owner] = 1'b0;
            end

            exp_send  = 1'b0;
            exp_ack   = 1'b0;
            byte_sent = 1'b0;

            if (in_word && nbytes == 2 && resp_cnt > 1 && !uart_send && $urandom_range(0, 7) == 0) begin
                // Abandon the word mid-flight; its requester keeps req high.
                rst_now    = 1'b1;
                rst        = 1'b1;
                in_word    = 1'b0;
                nbytes     = 0;
                ptr_m      = 0;
                resp_cnt   = 0;
                reset_seen = 1'b1;
            end else begin
                rst = 1'b0;
            end

            if (!rst_now) begin
                if (resp_cnt > 0 && !uart_send) begin
                    resp_cnt--;
                    if (resp_cnt == 0) begin
                        byte_sent = 1'b1;
                        if (nbytes == 4) exp_ack = 1'b1;
                        else exp_send = 1'b1;
                    end
                end
                // Spurious pulses where the transmitter must ignore them.
                if (!byte_sent && (uart_send || !in_word || ack_now) && $urandom_range(0, 3) == 0) begin
                    byte_sent = 1'b1;
                end

                for (int i = 0; i < N; i++) begin
                    if (!req[i] && !(in_word && cur_owner == i) && !(ack_now && cur_owner == i)
                        && $urandom_range(0, 7) == 0) begin
                        req[i] = 1'b1;
                        word_in[i*32 +: 32] = $urandom;
                    end
                end
                if ($urandom_range(0, 5) == 0) begin
                    word_in[$urandom_range(0, N-1)*32 +: 32] = $urandom;
                end
                if (in_word && $urandom_range(0, 15) == 0) begin
                    req[cur_owner] = 1'b0;
                end

                if (!in_word && !ack_now && (|req)) exp_send = 1'b1;
            end
        end

        check("words_completed", words_done > 20, 1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
